// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and state encoding for the CORDIC rotation/vectoring engines.
package cordic_pkg;
  localparam int W = 16;
  localparam int PIDIV2 = 201;
  localparam int PI = 402;
  localparam int ATAN [8] = '{100, 59, 31, 16, 8, 4, 2, 1};
  typedef enum logic [2:0] {GET, QUAD, CALC, MKC, PUT} state_t;
endpackage

// File: rtl/cordic_sra.sv
// cordic_sra: 16-bit arithmetic right barrel shift by a 3-bit amount.
import cordic_pkg::*;
module cordic_sra (
  input  logic signed [W-1:0] i_d,
  input  logic        [2:0]   i_s,
  output logic signed [W-1:0] o_q
);
  assign o_q = i_d >>> i_s;
endmodule

// File: rtl/cordic_vec.sv
// cordic_vec: iterative vectoring CORDIC, (x,y) -> (angle, magnitude).
// Define CORDIC_VEC_GAIN_EN to add the 3-cycle gain-compensation (MKC) stage.
import cordic_pkg::*;
module cordic_vec #(
  parameter int ITER = 8,
  parameter int AW   = 12
) (
  input  logic       ck,
  input  logic       raz,
  input  logic       wr_xy_p,
  input  logic [7:0] x_p,
  input  logic [7:0] y_p,
  output logic       wok_xy_p,
  input  logic       rd_am_p,
  output logic [9:0] na_p,
  output logic [8:0] nm_p,
  output logic       rok_am_p
);
  state_t r_st;
  logic signed [W-1:0] r_x, r_y, w_xs, w_ys, w_xc, w_yc;
  logic signed [AW-1:0] r_acc, w_ac, w_at;
  logic [2:0] r_i;
  logic r_z, r_wok;
`ifdef CORDIC_VEC_GAIN_EN
  logic signed [W-1:0] r_xo, w_xm;
`endif
  cordic_sra u_sx (.i_d(r_x), .i_s(r_i), .o_q(w_xs));
  cordic_sra u_sy (.i_d(r_y), .i_s(r_i), .o_q(w_ys));
  assign wok_xy_p = r_wok;
  always_comb begin
    w_at = AW'(ATAN[r_i]);
    w_xc = r_y[W-1] ? r_x - w_ys : r_x + w_ys;
    w_yc = r_y[W-1] ? r_y + w_xs : r_y - w_xs;
    w_ac = r_y[W-1] ? r_acc - w_at : r_acc + w_at;
`ifdef CORDIC_VEC_GAIN_EN
    // K = 2^-1+2^-4+2^-5+2^-7, built over three cycles from the held pre-gain X
    w_xm = (r_i == 3'd0) ? (r_x >>> 7) + (r_x >>> 5) : r_x + ((r_i == 3'd1) ? r_xo >>> 4 : r_xo >>> 1);
`endif
  end
  always_ff @(posedge ck or negedge raz) begin
    if (!raz) begin
      r_st <= GET;
      r_x <= '0;
      r_y <= '0;
      r_acc <= '0;
      r_i <= '0;
      r_z <= 1'b0;
      r_wok <= 1'b0;
      na_p <= '0;
      nm_p <= '0;
      rok_am_p <= 1'b0;
`ifdef CORDIC_VEC_GAIN_EN
      r_xo <= '0;
`endif
    end else begin
      case (r_st)
        GET: begin
          r_wok <= 1'b1;
          if (wr_xy_p && r_wok) begin
            r_x <= {{2{x_p[7]}}, x_p, 6'b0};
            r_y <= {{2{y_p[7]}}, y_p, 6'b0};
            r_acc <= '0;
            r_i <= '0;
            r_z <= (x_p == 8'd0) && (y_p == 8'd0);
            r_wok <= 1'b0;
            r_st <= QUAD;
          end
        end
        QUAD: begin
          // fold left half-plane into the right so CALC only covers +/-pi/2
          if (r_x[W-1]) begin
            r_x <= r_y[W-1] ? -r_y : r_y;
            r_y <= r_y[W-1] ? r_x : -r_x;
            r_acc <= r_y[W-1] ? -AW'(PIDIV2) : AW'(PIDIV2);
          end
          r_st <= CALC;
        end
        CALC: begin
          r_x <= w_xc;
          r_y <= w_yc;
          r_acc <= w_ac;
          r_i <= r_i + 3'd1;
          if (r_i == 3'(ITER - 1)) begin
            r_i <= '0;
`ifdef CORDIC_VEC_GAIN_EN
            r_st <= MKC;
`else
            r_st <= PUT;
            rok_am_p <= 1'b1;
            na_p <= r_z ? '0 : w_ac[9:0];
            nm_p <= r_z ? '0 : w_xc[14:6];
`endif
          end
        end
`ifdef CORDIC_VEC_GAIN_EN
        MKC: begin
          r_x <= w_xm;
          if (r_i == 3'd0) r_xo <= r_x;
          r_i <= r_i + 3'd1;
          if (r_i == 3'd2) begin
            r_i <= '0;
            r_st <= PUT;
            rok_am_p <= 1'b1;
            na_p <= r_z ? '0 : r_acc[9:0];
            nm_p <= r_z ? '0 : w_xm[14:6];
          end
        end
`endif
        PUT: begin
          if (rd_am_p) begin
            rok_am_p <= 1'b0;
            r_wok <= 1'b1;
            r_st <= GET;
          end
        end
        default: r_st <= GET;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_vec.sv
// tb_cordic_vec: randomized and directed checks of cordic_vec against a behavioural model.
module tb_cordic_vec;
`ifdef CORDIC_VEC_GAIN_EN
  localparam int LAT = 12;
  localparam real KG = 0.6016 * 1.6468;
`else
  localparam int LAT = 9;
  localparam real KG = 1.6468;
`endif
  logic ck = 1'b0, raz = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] xi = '0, yi = '0;
  logic wok, rok;
  logic [9:0] na;
  logic [8:0] nm;
  int nvec = 0, nerr = 0;

  cordic_vec dut (.ck(ck), .raz(raz), .wr_xy_p(wr), .x_p(xi), .y_p(yi), .wok_xy_p(wok),
                  .rd_am_p(rd), .na_p(na), .nm_p(nm), .rok_am_p(rok));

  always #5 ck = ~ck;

  function automatic void model(input logic [7:0] x, input logic [7:0] y,
                                output logic [9:0] ea, output logic [8:0] em);
    int vx, vy, a, nx, ny;
    int at[8] = '{100, 59, 31, 16, 8, 4, 2, 1};
    vx = int'($signed(x)) * 64;
    vy = int'($signed(y)) * 64;
    a = 0;
    if (vx < 0) begin
      if (vy >= 0) begin nx = vy; ny = -vx; a = 201; end
      else begin nx = -vy; ny = vx; a = -201; end
      vx = nx; vy = ny;
    end
    for (int i = 0; i < 8; i++) begin
      if (vy >= 0) begin nx = vx + (vy >>> i); ny = vy - (vx >>> i); a += at[i]; end
      else begin nx = vx - (vy >>> i); ny = vy + (vx >>> i); a -= at[i]; end
      vx = nx; vy = ny;
    end
`ifdef CORDIC_VEC_GAIN_EN
    vx = (vx >>> 7) + (vx >>> 5) + (vx >>> 4) + (vx >>> 1);
`endif
    ea = 10'(a);
    em = 9'(vx >>> 6);
    if (x == 8'd0 && y == 8'd0) begin ea = '0; em = '0; end
  endfunction

  task automatic accept(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    @(negedge ck);
    wr = 1'b1; xi = x; yi = y;
    while (!wok && n < 50) begin @(negedge ck); n++; end
    nvec++;
    if (!wok) begin nerr++; $display("FAIL accept_timeout wok=%b required 1", wok); end
    @(posedge ck); #1 wr = 1'b0;
  endtask

  task automatic wait_rok(output int lat);
    lat = 0;
    while (!rok && lat < 50) begin @(posedge ck); #1; lat++; end
  endtask

  task automatic take();
    @(negedge ck); rd = 1'b1;
    @(posedge ck); #1 rd = 1'b0;
  endtask

  task automatic run(input logic [7:0] x, input logic [7:0] y, input string nm_s,
                     output logic [9:0] oa, output logic [8:0] om);
    int lat;
    logic [9:0] ea;
    logic [8:0] em;
    model(x, y, ea, em);
    accept(x, y);
    wait_rok(lat);
    oa = na; om = nm;
    nvec += 3;
    if (lat !== LAT) begin nerr++; $display("FAIL %s latency got %0d required %0d", nm_s, lat, LAT); end
    if (na !== ea) begin nerr++; $display("FAIL %s na got %0d required %0d (x=%0d y=%0d)", nm_s, $signed(na), $signed(ea), $signed(x), $signed(y)); end
    if (nm !== em) begin nerr++; $display("FAIL %s nm got %0d required %0d (x=%0d y=%0d)", nm_s, nm, em, $signed(x), $signed(y)); end
    take();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ck);
    #1;
    nvec++;
    if ({wok, rok, na, nm} !== 21'd0) begin nerr++; $display("FAIL reset wok=%b rok=%b na=%0d nm=%0d required all 0", wok, rok, na, nm); end
    @(negedge ck) raz = 1'b1;
  endtask

  task automatic test_directed();
    logic [7:0] tx[6] = '{8'd64, 8'd0, 8'hC0, 8'hC0, 8'd127, 8'd40};
    logic [7:0] ty[6] = '{8'd0, 8'd64, 8'd0, 8'hFF, 8'd127, 8'hB0};
    logic [9:0] oa;
    logic [8:0] om;
    real ra, rm, mx, my;
    for (int k = 0; k < 6; k++) begin
      run(tx[k], ty[k], "directed", oa, om);
      mx = $itor($signed(tx[k])); my = $itor($signed(ty[k]));
      ra = $itor($signed(oa)) - $atan2(my, mx) * 128.0;
      rm = $itor(om) - KG * $sqrt(mx * mx + my * my);
      nvec += 2;
      if (ra > 3.0 || ra < -3.0) begin nerr++; $display("FAIL directed_angle k=%0d got %0d error %f", k, $signed(oa), ra); end
      if (rm > 4.0 || rm < -4.0) begin nerr++; $display("FAIL directed_mag k=%0d got %0d error %f", k, om, rm); end
    end
  endtask

  task automatic test_zero();
    logic [9:0] oa;
    logic [8:0] om;
    run(8'd0, 8'd0, "zero", oa, om);
    nvec++;
    if (oa !== 10'd0 || om !== 9'd0) begin nerr++; $display("FAIL zero na=%0d nm=%0d required 0 0", oa, om); end
  endtask

  task automatic test_random();
    logic [9:0] oa;
    logic [8:0] om;
    for (int k = 0; k < 40; k++) run(8'($urandom), 8'($urandom), "random", oa, om);
  endtask

  task automatic test_backpressure();
    logic [7:0] x = 8'($urandom), y = 8'($urandom);
    logic [9:0] ea, oa;
    logic [8:0] em, om;
    int lat;
    model(x, y, ea, em);
    accept(x, y);
    wait_rok(lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge ck); wr = 1'b1; xi = 8'($urandom); yi = 8'($urandom);
      @(posedge ck); #1;
      nvec++;
      if (rok !== 1'b1 || wok !== 1'b0 || na !== ea || nm !== em) begin
        nerr++;
        $display("FAIL backpressure k=%0d rok=%b wok=%b na=%0d nm=%0d required 1 0 %0d %0d", k, rok, wok, $signed(na), nm, $signed(ea), em);
      end
    end
    wr = 1'b0;
    take();
    run(8'd64, 8'd0, "after_bp", oa, om);
  endtask

  task automatic test_abort();
    logic [9:0] oa;
    logic [8:0] om;
    accept(8'd64, 8'd0);
    repeat (5) @(posedge ck);
    #1 raz = 1'b0;
    #1;
    nvec++;
    if ({wok, rok, na, nm} !== 21'd0) begin nerr++; $display("FAIL abort wok=%b rok=%b na=%0d nm=%0d required all 0", wok, rok, na, nm); end
    @(negedge ck) raz = 1'b1;
    run(8'd64, 8'd0, "after_abort", oa, om);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_random();
    test_backpressure();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
